// File: rtl/bus_timer_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : bus_timer_responder_if
// Description : Bridge-side timer port pair (write/read decode, data, status).
//               Carries match_irq only when TIMER_CMP_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_timer_responder_if;
    logic        we_from_cpu;
    logic        sel_timer_write;
    logic        sel_timer_read;
    logic [31:0] wdata_from_bridge;
    logic [31:0] rdata_to_bridge;
    logic        running;
    logic        tick;
`ifdef TIMER_CMP_EN
    logic        match_irq;
`endif

    modport master (
        output we_from_cpu,
        output sel_timer_write,
        output sel_timer_read,
        output wdata_from_bridge,
        input  rdata_to_bridge,
        input  running,
`ifdef TIMER_CMP_EN
        input  match_irq,
`endif
        input  tick
    );

    modport slave (
        input  we_from_cpu,
        input  sel_timer_write,
        input  sel_timer_read,
        input  wdata_from_bridge,
        output rdata_to_bridge,
        output running,
`ifdef TIMER_CMP_EN
        output match_irq,
`endif
        output tick
    );
endinterface
`default_nettype wire

// File: rtl/bus_timer_responder.sv
`default_nettype none
// ============================================================================
// Module      : bus_timer_responder
// Description : Memory-mapped prescaled 32-bit timer with STOP/START/CLEAR/LOAD
//               commands. Optional compare/match_irq under macro TIMER_CMP_EN.
//               CLK_DIV legal range 1..65535.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_timer_responder #(
    parameter int CLK_DIV = 100,
    parameter int CNT_W   = 32
) (
    input  wire logic            clk_from_cpu,
    input  wire logic            rst_from_cpu,
    bus_timer_responder_if.slave bus
);
    localparam logic [0:0] ST_STOP = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [1:0] CMD_STOP  = 2'b00;
    localparam logic [1:0] CMD_START = 2'b01;
    localparam logic [1:0] CMD_CLEAR = 2'b10;
    localparam logic [1:0] CMD_LOAD  = 2'b11;

    localparam int              PS_W    = 16;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_DIV - 1);

    logic [0:0]       state;
    logic [0:0]       state_next;
    logic [PS_W-1:0]  prescaler;
    logic [PS_W-1:0]  prescaler_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] count_inc;
    logic             run_flag;
    logic             tick_pulse;
    logic             wr_accept;
    logic             tick_event;
    logic             inc_taken;
    logic [1:0]       cmd;

    assign wr_accept  = bus.we_from_cpu & bus.sel_timer_write;
    assign cmd        = bus.wdata_from_bridge[31:30];
    assign tick_event = (state == ST_RUN) && (prescaler == PS_LAST);
    assign count_inc  = count + {{(CNT_W-1){1'b0}}, 1'b1};
    // An accepted command always beats a same-cycle tick, so the increment is lost.
    assign inc_taken  = tick_event & ~wr_accept;

    always_comb begin
        state_next     = state;
        prescaler_next = prescaler;
        count_next     = count;
        if (state == ST_RUN) begin
            prescaler_next = tick_event ? '0 : prescaler + {{(PS_W-1){1'b0}}, 1'b1};
            if (tick_event) begin
                count_next = count_inc;
            end
        end
        if (wr_accept) begin
            count_next     = count;
            prescaler_next = '0;
            case (cmd)
                CMD_STOP: begin
                    state_next     = ST_STOP;
                    prescaler_next = prescaler;
                end
                CMD_START: state_next = ST_RUN;
                CMD_CLEAR: count_next = '0;
                CMD_LOAD:  count_next = {{(CNT_W-30){bus.wdata_from_bridge[29]}},
                                         bus.wdata_from_bridge[29:0]};
                default:   state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk_from_cpu) begin
        if (rst_from_cpu) begin
            state      <= ST_STOP;
            prescaler  <= '0;
            count      <= '0;
            run_flag   <= 1'b0;
            tick_pulse <= 1'b0;
        end else begin
            state      <= state_next;
            prescaler  <= prescaler_next;
            count      <= count_next;
            run_flag   <= (state_next == ST_RUN);
            tick_pulse <= inc_taken;
        end
    end

    assign bus.rdata_to_bridge = count;
    assign bus.running         = run_flag;
    assign bus.tick            = tick_pulse;

`ifdef TIMER_CMP_EN
    logic [CNT_W-1:0] compare;
    logic             match_flag;
    logic             cmp_store;
    logic             match_clr;
    logic             match_set;

    assign cmp_store = bus.we_from_cpu & bus.sel_timer_read;
    assign match_clr = cmp_store | (wr_accept && (cmd == CMD_CLEAR));
    assign match_set = inc_taken && (count_inc == compare);

    always_ff @(posedge clk_from_cpu) begin
        if (rst_from_cpu) begin
            compare    <= '0;
            match_flag <= 1'b0;
        end else begin
            if (cmp_store) begin
                compare <= bus.wdata_from_bridge;
            end
            if (match_clr) begin
                match_flag <= 1'b0;
            end else if (match_set) begin
                match_flag <= 1'b1;
            end
        end
    end

    assign bus.match_irq = match_flag;
`else
    logic unused_rd_sel;
    assign unused_rd_sel = bus.sel_timer_read;
`endif
endmodule
`default_nettype wire

// File: tb/tb_bus_timer_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_timer_responder
// Description : Directed table-driven bench for bus_timer_responder (CLK_DIV=4)
//               plus a CLK_DIV=1 instance and multi-cycle corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_timer_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    bus_timer_responder_if bus  ();
    bus_timer_responder_if bus1 ();

    bus_timer_responder #(.CLK_DIV(4), .CNT_W(32)) dut (
        .clk_from_cpu (clk),
        .rst_from_cpu (rst),
        .bus          (bus)
    );

    bus_timer_responder #(.CLK_DIV(1), .CNT_W(32)) dut1 (
        .clk_from_cpu (clk),
        .rst_from_cpu (rst),
        .bus          (bus1)
    );

    typedef struct {
        logic        we;
        logic        sw;
        logic        sr;
        logic [31:0] wdata;
        int          edges;
        logic [31:0] exp_count;
        logic        exp_run;
        logic        exp_tick;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic we, input logic sw, input logic sr,
                       input logic [31:0] wd, input int edges,
                       input logic [31:0] c, input logic r, input logic t,
                       input string n);
        vec_t v;
        v.we = we; v.sw = sw; v.sr = sr; v.wdata = wd; v.edges = edges;
        v.exp_count = c; v.exp_run = r; v.exp_tick = t; v.name = n;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.we_from_cpu = 1'b0; bus.sel_timer_write = 1'b0;
        bus.sel_timer_read = 1'b0; bus.wdata_from_bridge = 32'h0;
    endtask

    task automatic check_state(input string name, input logic [31:0] c,
                               input logic r, input logic t);
        chk({name, ".count"},   bus.rdata_to_bridge, c);
        chk({name, ".running"}, {31'h0, bus.running}, {31'h0, r});
        chk({name, ".tick"},    {31'h0, bus.tick},    {31'h0, t});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_bus();
        bus1.we_from_cpu = 1'b0; bus1.sel_timer_write = 1'b0;
        bus1.sel_timer_read = 1'b0; bus1.wdata_from_bridge = 32'h0;

        //   we sw sr wdata          edges count          run tick name
        add(0, 0, 0, 32'h0000_0000, 20, 32'h0000_0000, 0, 0, "idle_after_reset");
        add(1, 1, 0, 32'h4000_0000,  1, 32'h0000_0000, 1, 0, "start");
        add(0, 0, 0, 32'h0000_0000,  3, 32'h0000_0000, 1, 0, "pre_first_tick");
        add(0, 0, 0, 32'h0000_0000,  1, 32'h0000_0001, 1, 1, "first_tick");
        add(0, 0, 0, 32'h0000_0000,  1, 32'h0000_0001, 1, 0, "tick_one_cycle");
        add(0, 0, 0, 32'h0000_0000, 35, 32'h0000_000A, 1, 1, "forty_cycles");
        add(1, 1, 0, 32'hC000_0005,  1, 32'h0000_0005, 1, 0, "load_5");
        add(1, 1, 0, 32'h0000_0000,  1, 32'h0000_0005, 0, 0, "stop");
        add(0, 0, 0, 32'h0000_0000, 50, 32'h0000_0005, 0, 0, "stop_hold");
        add(1, 1, 0, 32'h4000_0000,  1, 32'h0000_0005, 1, 0, "restart");
        add(0, 0, 0, 32'h0000_0000,  3, 32'h0000_0005, 1, 0, "restart_pre_tick");
        add(0, 0, 0, 32'h0000_0000,  1, 32'h0000_0006, 1, 1, "restart_tick");
        add(1, 1, 0, 32'hFFFF_FFFE,  1, 32'hFFFF_FFFE, 1, 0, "load_neg");
        add(0, 0, 0, 32'h0000_0000,  4, 32'hFFFF_FFFF, 1, 1, "to_max");
        add(0, 0, 0, 32'h0000_0000,  4, 32'h0000_0000, 1, 1, "wrap");
        add(0, 0, 0, 32'h0000_0000,  3, 32'h0000_0000, 1, 0, "before_clr_tick");
        add(1, 1, 0, 32'h8000_0000,  1, 32'h0000_0000, 1, 0, "clear_on_tick");
        add(0, 0, 0, 32'h0000_0000,  3, 32'h0000_0000, 1, 0, "after_clr_pre");
        add(0, 0, 0, 32'h0000_0000,  1, 32'h0000_0001, 1, 1, "after_clr_tick");
        add(0, 0, 0, 32'h0000_0000,  1, 32'h0000_0001, 1, 0, "ps_one");
        add(1, 1, 0, 32'h8000_0000,  1, 32'h0000_0000, 1, 0, "clear_mid_phase");
        add(0, 0, 0, 32'h0000_0000,  3, 32'h0000_0000, 1, 0, "clr_phase_pre");
        add(0, 0, 0, 32'h0000_0000,  1, 32'h0000_0001, 1, 1, "clr_phase_tick");
        add(1, 0, 1, 32'h8000_0000,  1, 32'h0000_0001, 1, 0, "rd_sel_store");
        add(1, 0, 0, 32'h8000_0000,  1, 32'h0000_0001, 1, 0, "we_no_sel");
        add(0, 1, 0, 32'h8000_0000,  1, 32'h0000_0001, 1, 0, "sel_no_we");
        add(0, 0, 0, 32'h0000_0000,  1, 32'h0000_0002, 1, 1, "tick_after_ignored");
        add(1, 1, 0, 32'hD000_0000,  1, 32'h1000_0000, 1, 0, "load_pos");
        add(0, 0, 0, 32'h0000_0000,  2, 32'h1000_0000, 1, 0, "mid_phase");
        add(1, 1, 0, 32'h4000_0000,  1, 32'h1000_0000, 1, 0, "start_while_run");
        add(0, 0, 0, 32'h0000_0000,  3, 32'h1000_0000, 1, 0, "rerun_pre_tick");
        add(0, 0, 0, 32'h0000_0000,  1, 32'h1000_0001, 1, 1, "rerun_tick");

        rst = 1'b1;
        repeat (3) edge1();
        check_state("reset", 32'h0, 1'b0, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            bus.we_from_cpu       = vecs[i].we;
            bus.sel_timer_write   = vecs[i].sw;
            bus.sel_timer_read    = vecs[i].sr;
            bus.wdata_from_bridge = vecs[i].wdata;
            edge1();
            idle_bus();
            for (int k = 1; k < vecs[i].edges; k++) edge1();
            check_state(vecs[i].name, vecs[i].exp_count, vecs[i].exp_run, vecs[i].exp_tick);
        end

        // Read in the same cycle as a store sees the pre-write count.
        bus.we_from_cpu = 1'b1; bus.sel_timer_write = 1'b1;
        bus.wdata_from_bridge = 32'hC000_0123;
        #1;
        chk("rd_during_wr", bus.rdata_to_bridge, 32'h1000_0001);
        edge1();
        idle_bus();
        chk("rd_after_wr", bus.rdata_to_bridge, 32'h0000_0123);

        // Reset beats a simultaneous START.
        rst = 1'b1;
        bus.we_from_cpu = 1'b1; bus.sel_timer_write = 1'b1;
        bus.wdata_from_bridge = 32'h4000_0000;
        edge1();
        check_state("rst_vs_start", 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        idle_bus();
        repeat (8) edge1();
        check_state("rst_vs_start_idle", 32'h0, 1'b0, 1'b0);

        // CLK_DIV=1: tick every cycle while running.
        bus1.we_from_cpu = 1'b1; bus1.sel_timer_write = 1'b1;
        bus1.wdata_from_bridge = 32'h4000_0000;
        edge1();
        bus1.we_from_cpu = 1'b0; bus1.sel_timer_write = 1'b0;
        bus1.wdata_from_bridge = 32'h0;
        chk("div1_start.running", {31'h0, bus1.running}, 32'h1);
        chk("div1_start.count", bus1.rdata_to_bridge, 32'h0);
        for (int k = 1; k <= 5; k++) begin
            edge1();
            chk($sformatf("div1_tick%0d.count", k), bus1.rdata_to_bridge, k);
            chk($sformatf("div1_tick%0d.tick", k), {31'h0, bus1.tick}, 32'h1);
        end

`ifdef TIMER_CMP_EN
        chk("cmp_reset", {31'h0, bus.match_irq}, 32'h0);
        bus.we_from_cpu = 1'b1; bus.sel_timer_read = 1'b1;
        bus.wdata_from_bridge = 32'h0000_0003;
        edge1();
        bus.sel_timer_read = 1'b0; bus.sel_timer_write = 1'b1;
        bus.wdata_from_bridge = 32'h4000_0000;
        edge1();
        idle_bus();
        repeat (11) edge1();
        chk("cmp_pre.count", bus.rdata_to_bridge, 32'h2);
        chk("cmp_pre.match", {31'h0, bus.match_irq}, 32'h0);
        edge1();
        chk("cmp_hit.count", bus.rdata_to_bridge, 32'h3);
        chk("cmp_hit.match", {31'h0, bus.match_irq}, 32'h1);
        repeat (4) edge1();
        chk("cmp_sticky.count", bus.rdata_to_bridge, 32'h4);
        chk("cmp_sticky.match", {31'h0, bus.match_irq}, 32'h1);
        bus.we_from_cpu = 1'b1; bus.sel_timer_read = 1'b1;
        bus.wdata_from_bridge = 32'h0000_0009;
        edge1();
        idle_bus();
        chk("cmp_store_clr.match", {31'h0, bus.match_irq}, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
